// File: rtl/lpd_pkg.sv
// Shared definitions for the LM_ULM load/unload path: BRAM geometry, region
// constants, responder state encoding and address arithmetic.
package lpd_pkg;

  localparam int unsigned PNL_BRAM_ADDR_SIZE_NB   = 32'd15;
  localparam int unsigned PNL_BRAM_DBITS_WIDTH_NB = 32'd16;

  localparam logic [PNL_BRAM_ADDR_SIZE_NB-1:0] PN_BRAM_BASE           = 15'd0;
  localparam logic [PNL_BRAM_ADDR_SIZE_NB-1:0] PN_BRAM_UPPER_LIMIT    = 15'd16383;
  localparam logic [PNL_BRAM_ADDR_SIZE_NB-1:0] HISTO_BRAM_BASE        = 15'd24576;
  localparam logic [PNL_BRAM_ADDR_SIZE_NB-1:0] HISTO_BRAM_UPPER_LIMIT = 15'd28671;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LD_WAIT    = 3'd1,
    LD_RELEASE = 3'd2,
    UL_FETCH   = 3'd3,
    UL_CAPTURE = 3'd4,
    UL_WAIT    = 3'd5,
    UL_RELEASE = 3'd6,
    DONE       = 3'd7
  } lm_ulm_state_t;

  // Wraps modulo the BRAM size, so a range may cross address 0.
  function automatic logic [PNL_BRAM_ADDR_SIZE_NB-1:0] addr_inc(
    input logic [PNL_BRAM_ADDR_SIZE_NB-1:0] addr
  );
    return addr + 15'd1;
  endfunction

endpackage

// File: rtl/load_unload_mem_if.sv
// Controller + C-program GPIO handshake bundle for the LM_ULM responder.
interface load_unload_mem_if;

  logic                                         start;
  logic                                         ready;
  logic                                         load_unload;
  logic [lpd_pkg::PNL_BRAM_ADDR_SIZE_NB-1:0]    base_address;
  logic [lpd_pkg::PNL_BRAM_ADDR_SIZE_NB-1:0]    upper_limit;
  logic                                         CP_continue;
  logic [lpd_pkg::PNL_BRAM_DBITS_WIDTH_NB-1:0]  data_from_cp;
  logic                                         LM_ULM_stopped;
  logic                                         LM_ULM_done;
  logic [lpd_pkg::PNL_BRAM_DBITS_WIDTH_NB-1:0]  data_to_cp;

  modport master (
    output start, load_unload, base_address, upper_limit, CP_continue, data_from_cp,
    input  ready, LM_ULM_stopped, LM_ULM_done, data_to_cp
  );

  modport slave (
    input  start, load_unload, base_address, upper_limit, CP_continue, data_from_cp,
    output ready, LM_ULM_stopped, LM_ULM_done, data_to_cp
  );

endinterface

// File: rtl/load_unload_mem_cp_sync.sv
// Two-flop level synchronizer for GPIO bits arriving from the processor side.
module cp_sync #(
  parameter int unsigned WIDTH = 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/load_unload_mem.sv
// LM_ULM responder: moves an inclusive, wrapping word range between the C
// program and PNL BRAM port A, one word per CP_continue handshake.
module load_unload_mem
  import lpd_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  load_unload_mem_if.slave                   lm,
  output logic [PNL_BRAM_ADDR_SIZE_NB-1:0]   PNL_BRAM_addr,
  output logic [PNL_BRAM_DBITS_WIDTH_NB-1:0] PNL_BRAM_din,
  output logic                               PNL_BRAM_we,
  input  logic [PNL_BRAM_DBITS_WIDTH_NB-1:0] PNL_BRAM_dout
);

  lm_ulm_state_t                      state_r;
  lm_ulm_state_t                      state_s;
  logic [PNL_BRAM_ADDR_SIZE_NB-1:0]   addr_r;
  logic [PNL_BRAM_ADDR_SIZE_NB-1:0]   upper_r;
  logic [PNL_BRAM_DBITS_WIDTH_NB-1:0] data_to_cp_r;
  logic                               ready_r;
  logic                               stopped_r;
  logic                               done_r;
  logic                               cont_s;
  logic                               last_s;
  logic                               latch_s;
  logic                               incr_s;
  logic                               capture_s;
  logic                               we_s;

  cp_sync #(.WIDTH(32'd1)) u_cp_sync (
    .clk   (clk),
    .reset (reset),
    .d     (lm.CP_continue),
    .q     (cont_s)
  );

  assign last_s = (addr_r == upper_r);

  // Next-state and per-cycle strobes for the handshake sequencer.
  always_comb begin
    state_s   = state_r;
    latch_s   = 1'b0;
    incr_s    = 1'b0;
    capture_s = 1'b0;
    we_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (lm.start) begin
          latch_s = 1'b1;
          state_s = lm.load_unload ? UL_FETCH : LD_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      LD_WAIT: begin
        if (cont_s) begin
          we_s    = 1'b1;
          state_s = LD_RELEASE;
        end else begin
          state_s = LD_WAIT;
        end
      end
      LD_RELEASE: begin
        if (!cont_s) begin
          if (last_s) begin
            state_s = DONE;
          end else begin
            incr_s  = 1'b1;
            state_s = LD_WAIT;
          end
        end else begin
          state_s = LD_RELEASE;
        end
      end
      UL_FETCH: begin
        state_s = UL_CAPTURE;
      end
      UL_CAPTURE: begin
        capture_s = 1'b1;
        state_s   = UL_WAIT;
      end
      UL_WAIT: begin
        if (cont_s) begin
          state_s = UL_RELEASE;
        end else begin
          state_s = UL_WAIT;
        end
      end
      UL_RELEASE: begin
        if (!cont_s) begin
          if (last_s) begin
            state_s = DONE;
          end else begin
            incr_s  = 1'b1;
            state_s = UL_FETCH;
          end
        end else begin
          state_s = UL_RELEASE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched range and status flags; flags decode the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= {PNL_BRAM_ADDR_SIZE_NB{1'b0}};
      upper_r      <= {PNL_BRAM_ADDR_SIZE_NB{1'b0}};
      data_to_cp_r <= {PNL_BRAM_DBITS_WIDTH_NB{1'b0}};
      ready_r      <= 1'b1;
      stopped_r    <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r   <= state_s;
      ready_r   <= (state_s == IDLE);
      stopped_r <= (state_s == LD_WAIT) || (state_s == UL_WAIT);
      done_r    <= (state_s == DONE);
      if (latch_s) begin
        addr_r  <= lm.base_address;
        upper_r <= lm.upper_limit;
      end else if (incr_s) begin
        addr_r  <= addr_inc(addr_r);
      end
      if (capture_s) begin
        data_to_cp_r <= PNL_BRAM_dout;
      end
    end
  end

  assign lm.ready          = ready_r;
  assign lm.LM_ULM_stopped = stopped_r;
  assign lm.LM_ULM_done    = done_r;
  assign lm.data_to_cp     = data_to_cp_r;

  // Write strobe is a single gate on two flops so it coincides with the
  // synchronized CP_continue edge rather than trailing it by a cycle.
  assign PNL_BRAM_addr = addr_r;
  assign PNL_BRAM_din  = lm.data_from_cp;
  assign PNL_BRAM_we   = we_s;

endmodule

// File: tb/tb_load_unload_mem.sv
// Directed bench for load_unload_mem with a one-cycle-latency BRAM model.
module tb_load_unload_mem;
  import lpd_pkg::*;

  logic        clk;
  logic        reset;
  logic [14:0] bram_addr;
  logic [15:0] bram_din;
  logic [15:0] bram_dout;
  logic        bram_we;

  logic [15:0] mem [0:32767];
  logic [14:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];

  int checks = 0;
  int errors = 0;

  load_unload_mem_if lm();

  load_unload_mem dut (
    .clk           (clk),
    .reset         (reset),
    .lm            (lm),
    .PNL_BRAM_addr (bram_addr),
    .PNL_BRAM_din  (bram_din),
    .PNL_BRAM_we   (bram_we),
    .PNL_BRAM_dout (bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_we) begin
      mem[bram_addr] <= bram_din;
      wr_addr_q.push_back(bram_addr);
      wr_data_q.push_back(bram_din);
    end
    bram_dout <= mem[bram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic mode, input logic [14:0] base, input logic [14:0] upper);
    lm.load_unload  = mode;
    lm.base_address = base;
    lm.upper_limit  = upper;
    lm.start        = 1'b1;
    tick();
    lm.start        = 1'b0;
  endtask

  // Drop CP_continue and wait until the next word is pending or the range is done.
  task automatic release_word(input string tag);
    int n;
    lm.CP_continue = 1'b0;
    n = 0;
    tick();
    while (!lm.LM_ULM_stopped && !lm.LM_ULM_done && n < 12) begin
      tick();
      n++;
    end
    check({tag, "/release"}, {31'd0, lm.LM_ULM_stopped | lm.LM_ULM_done}, 32'd1);
  endtask

  task automatic load_word(input logic [15:0] d, input string tag);
    int n;
    lm.data_from_cp = d;
    lm.CP_continue  = 1'b1;
    n = 0;
    tick();
    while (lm.LM_ULM_stopped && n < 12) begin
      tick();
      n++;
    end
    check({tag, "/press"}, {31'd0, lm.LM_ULM_stopped}, 32'd0);
    release_word(tag);
  endtask

  task automatic unload_word(input logic [15:0] exp, input string tag);
    int n;
    n = 0;
    while (!lm.LM_ULM_stopped && n < 12) begin
      tick();
      n++;
    end
    check({tag, "/stopped"}, {31'd0, lm.LM_ULM_stopped}, 32'd1);
    check({tag, "/data"}, {16'd0, lm.data_to_cp}, {16'd0, exp});
    lm.CP_continue = 1'b1;
    n = 0;
    tick();
    while (lm.LM_ULM_stopped && n < 12) begin
      check({tag, "/stable"}, {16'd0, lm.data_to_cp}, {16'd0, exp});
      tick();
      n++;
    end
    check({tag, "/press"}, {31'd0, lm.LM_ULM_stopped}, 32'd0);
    release_word(tag);
  endtask

  // Done must be a single pulse followed by ready.
  task automatic check_done(input string tag);
    check({tag, "/done"}, {31'd0, lm.LM_ULM_done}, 32'd1);
    check({tag, "/ready_in_done"}, {31'd0, lm.ready}, 32'd0);
    tick();
    check({tag, "/done_drop"}, {31'd0, lm.LM_ULM_done}, 32'd0);
    check({tag, "/ready"}, {31'd0, lm.ready}, 32'd1);
  endtask

  task automatic check_write(input int idx, input logic [14:0] a, input logic [15:0] d, input string tag);
    if (idx < wr_addr_q.size()) begin
      check({tag, "/wr_addr"}, {17'd0, wr_addr_q[idx]}, {17'd0, a});
      check({tag, "/wr_data"}, {16'd0, wr_data_q[idx]}, {16'd0, d});
    end else begin
      check({tag, "/wr_missing"}, wr_addr_q.size(), idx + 1);
    end
  endtask

  initial begin
    reset           = 1'b1;
    lm.start        = 1'b0;
    lm.load_unload  = 1'b0;
    lm.base_address = 15'd0;
    lm.upper_limit  = 15'd0;
    lm.CP_continue  = 1'b0;
    lm.data_from_cp = 16'd0;
    tick();
    tick();
    tick();
    check("rst/ready",   {31'd0, lm.ready},          32'd1);
    check("rst/stopped", {31'd0, lm.LM_ULM_stopped}, 32'd0);
    check("rst/done",    {31'd0, lm.LM_ULM_done},    32'd0);
    check("rst/we",      {31'd0, bram_we},           32'd0);
    check("rst/addr",    {17'd0, bram_addr},         32'd0);
    check("rst/dtocp",   {16'd0, lm.data_to_cp},     32'd0);
    reset = 1'b0;
    tick();

    // Load 0..3 with exact cycle timing on the first word.
    start_xfer(1'b0, 15'd0, 15'd3);
    check("ld/ready_low", {31'd0, lm.ready},          32'd0);
    check("ld/stopped",   {31'd0, lm.LM_ULM_stopped}, 32'd1);
    lm.data_from_cp = 16'h1111;
    lm.CP_continue  = 1'b1;
    tick();
    check("ld/we_c1", {31'd0, bram_we}, 32'd0);
    tick();
    check("ld/we_c2",      {31'd0, bram_we},           32'd1);
    check("ld/addr_c2",    {17'd0, bram_addr},         32'd0);
    check("ld/din_c2",     {16'd0, bram_din},          32'h1111);
    check("ld/stopped_c2", {31'd0, lm.LM_ULM_stopped}, 32'd1);
    tick();
    check("ld/we_c3",      {31'd0, bram_we},           32'd0);
    check("ld/stopped_c3", {31'd0, lm.LM_ULM_stopped}, 32'd0);
    release_word("ld0");
    load_word(16'h2222, "ld1");
    load_word(16'h3333, "ld2");
    load_word(16'h4444, "ld3");
    check_done("ld");
    check("ld/count", wr_addr_q.size(), 32'd4);
    check_write(0, 15'd0, 16'h1111, "ld0");
    check_write(1, 15'd1, 16'h2222, "ld1");
    check_write(2, 15'd2, 16'h3333, "ld2");
    check_write(3, 15'd3, 16'h4444, "ld3");

    // Fill the histogram region, then stream it back.
    start_xfer(1'b0, 15'd24576, 15'd24578);
    load_word(16'h00A0, "fill0");
    load_word(16'h00B1, "fill1");
    load_word(16'h00C2, "fill2");
    check_done("fill");
    wr_addr_q.delete();
    wr_data_q.delete();
    tick();
    start_xfer(1'b1, 15'd24576, 15'd24578);
    check("ul/stopped_f", {31'd0, lm.LM_ULM_stopped}, 32'd0);
    check("ul/addr_f",    {17'd0, bram_addr},         32'd24576);
    tick();
    check("ul/stopped_c", {31'd0, lm.LM_ULM_stopped}, 32'd0);
    tick();
    check("ul/stopped_w", {31'd0, lm.LM_ULM_stopped}, 32'd1);
    check("ul/data_w",    {16'd0, lm.data_to_cp},     32'h00A0);
    unload_word(16'h00A0, "ul0");
    unload_word(16'h00B1, "ul1");
    unload_word(16'h00C2, "ul2");
    check_done("ul");
    check("ul/no_writes", wr_addr_q.size(), 32'd0);

    // Single-word range.
    start_xfer(1'b0, 15'd100, 15'd100);
    load_word(16'h5A5A, "one");
    check_done("one");
    check("one/count", wr_addr_q.size(), 32'd1);
    check_write(0, 15'd100, 16'h5A5A, "one");
    wr_addr_q.delete();
    wr_data_q.delete();

    // Range wrapping through address 0.
    start_xfer(1'b0, 15'd32766, 15'd1);
    load_word(16'h0E01, "wr0");
    load_word(16'h0E02, "wr1");
    load_word(16'h0E03, "wr2");
    load_word(16'h0E04, "wr3");
    check_done("wrap");
    check("wrap/count", wr_addr_q.size(), 32'd4);
    check_write(0, 15'd32766, 16'h0E01, "wr0");
    check_write(1, 15'd32767, 16'h0E02, "wr1");
    check_write(2, 15'd0,     16'h0E03, "wr2");
    check_write(3, 15'd1,     16'h0E04, "wr3");
    wr_addr_q.delete();
    wr_data_q.delete();

    // Inputs and start disturbed mid-transfer.
    start_xfer(1'b0, 15'd200, 15'd201);
    load_word(16'h0200, "mid0");
    start_xfer(1'b1, 15'd500, 15'd600);
    check("mid/stopped", {31'd0, lm.LM_ULM_stopped}, 32'd1);
    check("mid/addr",    {17'd0, bram_addr},         32'd201);
    load_word(16'h0201, "mid1");
    check_done("mid");
    check("mid/count", wr_addr_q.size(), 32'd2);
    check_write(0, 15'd200, 16'h0200, "mid0");
    check_write(1, 15'd201, 16'h0201, "mid1");
    wr_addr_q.delete();
    wr_data_q.delete();

    // Reset while waiting in LD_WAIT with CP_continue raised.
    start_xfer(1'b0, 15'd300, 15'd305);
    tick();
    check("rmid/stopped_pre", {31'd0, lm.LM_ULM_stopped}, 32'd1);
    lm.data_from_cp = 16'hDEAD;
    lm.CP_continue  = 1'b1;
    reset           = 1'b1;
    tick();
    check("rmid/we",      {31'd0, bram_we},           32'd0);
    check("rmid/ready",   {31'd0, lm.ready},          32'd1);
    check("rmid/stopped", {31'd0, lm.LM_ULM_stopped}, 32'd0);
    check("rmid/addr",    {17'd0, bram_addr},         32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rmid/we_after", {31'd0, bram_we}, 32'd0);
    end
    check("rmid/no_writes", wr_addr_q.size(), 32'd0);
    lm.CP_continue = 1'b0;
    tick();
    tick();
    tick();
    start_xfer(1'b0, 15'd7, 15'd7);
    load_word(16'h7777, "fresh");
    check_done("fresh");
    check("fresh/count", wr_addr_q.size(), 32'd1);
    check_write(0, 15'd7, 16'h7777, "fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_unload_mem.md
# load_unload_mem

Responder side of the LM_ULM interface. On a start pulse it moves a contiguous word range between the C program and the PNL BRAM, one word per GPIO handshake. Load mode writes C program data into BRAM; unload mode streams BRAM words back to the C program. It sits between the top-level controller, the GPIO register block and BRAM port A.

## Interface
- PNL_BRAM_ADDR_SIZE_NB, 15, BRAM address width
- PNL_BRAM_DBITS_WIDTH_NB, 16, BRAM/GPIO data width
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request from the controller; sampled only in IDLE
- ready  out  1  high only in IDLE; reset value 1
- load_unload  in  1  0 = load (C→BRAM), 1 = unload (BRAM→C); latched on start
- base_address  in  ADDR  first word address; latched on start
- upper_limit  in  ADDR  last word address, inclusive; latched on start
- CP_continue  in  1  C program strobe (asynchronous GPIO bit)
- data_from_cp  in  DBITS  C program write data; stable while CP_continue is high
- LM_ULM_stopped  out  1  high while waiting for the C program to act on the current word; reset 0
- LM_ULM_done  out  1  one-cycle pulse when the range is complete; reset 0
- data_to_cp  out  DBITS  registered unload word; reset 0
- PNL_BRAM_addr  out  ADDR  BRAM address; reset 0
- PNL_BRAM_din  out  DBITS  BRAM write data (= data_from_cp)
- PNL_BRAM_we  out  1  BRAM write enable; reset 0
- PNL_BRAM_dout  in  DBITS  BRAM read data; 1-cycle read latency

## Operation
- CP_continue passes through a 2-FF synchronizer. Internal signal: cont_s. All handshake decisions use cont_s.
- States: IDLE, LD_WAIT, LD_RELEASE, UL_FETCH, UL_CAPTURE, UL_WAIT, UL_RELEASE, DONE.
- IDLE: ready=1. On start, latch the mode, base and limit, and set addr_r=base_address. Go to LD_WAIT (mode 0) or UL_FETCH (mode 1).
- LD_WAIT: stopped=1. When cont_s=1: we=1 for exactly this cycle, addr=addr_r, din=data_from_cp. Then go to LD_RELEASE.
- LD_RELEASE: stopped=0. Wait for cont_s=0. Then go to DONE if addr_r==upper_r; otherwise addr_r+1 and go to LD_WAIT.
- UL_FETCH: drive addr_r and go to UL_CAPTURE.
- UL_CAPTURE: data_to_cp ← PNL_BRAM_dout. Go to UL_WAIT.
- UL_WAIT: stopped=1. When cont_s=1, go to UL_RELEASE.
- UL_RELEASE: stopped=0. Wait for cont_s=0. Then go to DONE if addr_r==upper_r; otherwise addr_r+1 and go to UL_FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR. upper_limit < base_address wraps through 0 and ends at upper_limit; this is legal.
- base_address==upper_limit transfers exactly one word.
- start outside IDLE is ignored. The latched parameters are immune to input changes mid-transfer.
- Reset mid-transfer: next cycle is IDLE, with no further BRAM write and all outputs at reset values. A partially written range is left as-is.

## Timing
- start at cycle T: ready=0 at T+1, so the controller sees not-ready on its first wait cycle.
- Load: CP_continue rises at C. The write happens at C+2 (synchronizer), and stopped falls at C+3.
- Unload: data_to_cp is valid 2 cycles after entering UL_FETCH, and stopped rises in the same cycle data is valid. The C program must read data_to_cp only while stopped=1.
- Per-word minimum: 2+2 synchronizer cycles per CP_continue edge, plus 1 (load) or 3 (unload) cycles.
- The last word's release is followed by DONE in the next cycle; IDLE/ready=1 one cycle later.
- PNL_BRAM_we is never high outside LD_WAIT.

## Structure
- Shared package lpd_pkg holds PNL_BRAM_ADDR_SIZE_NB, PNL_BRAM_DBITS_WIDTH_NB, PN_BRAM_BASE, the histogram base/limit constants and the lm_ulm_state_t enum. The controller imports the same package.
- One sub-module, cp_sync (2-FF level synchronizer, parameterized width), instantiated for CP_continue.

## Test plan
- Load base=0, upper=3, C data 0x1111..0x4444 → four single-cycle writes to addr 0..3 with matching din; one done pulse; ready returns high.
- Unload base=24576, upper=24578, BRAM holds 0xA0,0xB1,0xC2 → data_to_cp shows 0xA0,0xB1,0xC2 in order, each stable while stopped=1.
- base=upper=100 in load mode → exactly one write at addr 100, then done.
- base=32766, upper=1 → writes at 32766, 32767, 0, 1 (wrap), then done.
- start pulsed and base/limit inputs changed mid-load → transfer continues on the latched range; no restart.
- reset asserted in LD_WAIT with CP_continue high → we stays 0, ready=1 and stopped=0 the next cycle; a fresh start then works normally.
